// File: rtl/alu_8bit.sv
// ============================================================================
// Module   : alu_8bit
// Purpose  : Registered 16-opcode ALU with carry, valid strobe, 1-cycle latency.
//            Optional Zero flag output when ALU_ZERO_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
`ifdef ALU_ZERO_FLAG_EN
  output logic             Zero,
`endif
  output logic             out_valid
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
`ifdef ALU_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  always_comb begin
    sum    = {1'b0, A} + {1'b0, B};
    result = '0;
    case (ALU_Sel)
      OP_ADD:  result = sum[WIDTH-1:0];
      OP_SUB:  result = A - B;
      OP_MUL:  result = A * B;
      // Divide-by-zero saturates to all-ones instead of trapping.
      OP_DIV:  result = (B == '0) ? '1 : A / B;
      OP_SHL:  result = A << 1;
      OP_SHR:  result = A >> 1;
      OP_ROL:  result = {A[WIDTH-2:0], A[WIDTH-1]};
      OP_ROR:  result = {A[0], A[WIDTH-1:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (A == B)};
      default: result = '0;
    endcase
  end

  always_comb begin
    alu_out_d = alu_out_q;
    carry_d   = carry_q;
    valid_d   = in_valid;
`ifdef ALU_ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    if (in_valid) begin
      alu_out_d = result;
      carry_d   = sum[WIDTH];
`ifdef ALU_ZERO_FLAG_EN
      zero_d    = (result == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      valid_q   <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
      valid_q   <= valid_d;
`ifdef ALU_ZERO_FLAG_EN
      zero_q    <= zero_d;
`endif
    end
  end

  assign ALU_Out   = alu_out_q;
  assign CarryOut  = carry_q;
  assign out_valid = valid_q;
`ifdef ALU_ZERO_FLAG_EN
  assign Zero      = zero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_8bit.sv
// ============================================================================
// Module   : tb_alu_8bit
// Purpose  : Self-checking bench for alu_8bit: arithmetic reference model plus
//            literal vectors. Zero flag checked when ALU_ZERO_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_8bit;

  localparam int WIDTH = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             out_valid;
`ifdef ALU_ZERO_FLAG_EN
  logic             Zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_8bit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut),
`ifdef ALU_ZERO_FLAG_EN
    .Zero     (Zero),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode's definition.
  function automatic int model_result(input int a, input int b, input int sel);
    int r;
    case (sel)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3:  r = (b == 0) ? MASK : a / b;
      4:  r = a * 2;
      5:  r = a / 2;
      6:  r = a * 2 + a / (1 << (WIDTH - 1));
      7:  r = a / 2 + (a % 2) * (1 << (WIDTH - 1));
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = ~(a | b);
      12: r = ~(a & b);
      13: r = ~(a ^ b);
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return r & MASK;
  endfunction

  int exp_out   = 0;
  bit exp_carry = 1'b0;
  bit exp_valid = 1'b0;
  bit exp_zero  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out = 0; exp_carry = 1'b0; exp_valid = 1'b0; exp_zero = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        exp_out   = model_result(int'(A), int'(B), int'(ALU_Sel));
        exp_carry = ((int'(A) + int'(B)) >> WIDTH) & 1;
        exp_zero  = (exp_out == 0);
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    check("cmp_out",   {24'd0, ALU_Out},   exp_out);
    check("cmp_carry", {31'd0, CarryOut},  {31'd0, exp_carry});
`ifdef ALU_ZERO_FLAG_EN
    check("cmp_zero",  {31'd0, Zero},      {31'd0, exp_zero});
`endif
  end

  task automatic lit(input string nm, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] s, input logic [7:0] eo, input logic ec);
    @(negedge clk);
    A = a; B = b; ALU_Sel = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, "_out"},   {24'd0, ALU_Out},  {24'd0, eo});
    check({nm, "_carry"}, {31'd0, CarryOut}, {31'd0, ec});
    check({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  logic [7:0] hold_val;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALU_Sel = '0;
    #1;
    check("rst_out",   {24'd0, ALU_Out},   32'd0);
    check("rst_carry", {31'd0, CarryOut},  32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    #12 rst_n = 1'b1;

    lit("mul",     8'h0A, 8'h05, 4'b0010, 8'h32, 1'b0);
    lit("mul_tr",  8'h20, 8'h10, 4'b0010, 8'h00, 1'b0);
    lit("add_c",   8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1);
    lit("sub",     8'h03, 8'h05, 4'b0001, 8'hFE, 1'b0);
    lit("div",     8'h64, 8'h07, 4'b0011, 8'h0E, 1'b0);
    lit("div0",    8'h64, 8'h00, 4'b0011, 8'hFF, 1'b0);
    lit("rol",     8'h81, 8'h00, 4'b0110, 8'h03, 1'b0);
    lit("ror",     8'h81, 8'h00, 4'b0111, 8'hC0, 1'b0);
    lit("mul_cy",  8'h80, 8'h80, 4'b0010, 8'h00, 1'b1);
    lit("and",     8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b1);
    lit("or",      8'hF0, 8'h3C, 4'b1001, 8'hFC, 1'b1);
    lit("xor",     8'hF0, 8'h3C, 4'b1010, 8'hCC, 1'b1);
    lit("nor",     8'hF0, 8'h3C, 4'b1011, 8'h03, 1'b1);
    lit("nand",    8'hF0, 8'h3C, 4'b1100, 8'hCF, 1'b1);
    lit("xnor",    8'hF0, 8'h3C, 4'b1101, 8'h33, 1'b1);
    lit("gt",      8'hF0, 8'h3C, 4'b1110, 8'h01, 1'b1);
    lit("eq_no",   8'hF0, 8'h3C, 4'b1111, 8'h00, 1'b1);
    lit("eq_yes",  8'h5A, 8'h5A, 4'b1111, 8'h01, 1'b0);
    lit("shl",     8'hC3, 8'h00, 4'b0100, 8'h86, 1'b0);
    lit("shr",     8'hC3, 8'h00, 4'b0101, 8'h61, 1'b0);
    lit("gt_eq",   8'h5A, 8'h5A, 4'b1110, 8'h00, 1'b0);

`ifdef ALU_ZERO_FLAG_EN
    lit("zflag",   8'h5A, 8'h5A, 4'b1010, 8'h00, 1'b0);
    check("zflag_zero", {31'd0, Zero}, 32'd1);
`endif

    // Back-to-back issue across every opcode with varied operands.
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      A = 8'($urandom_range(0, 255));
      B = (i % 7 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      ALU_Sel = 4'(i % 16);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    hold_val = ALU_Out;
    A = 8'h12; B = 8'h34; ALU_Sel = 4'b0000;
    repeat (3) @(negedge clk);
    check("idle_hold",  {24'd0, ALU_Out},   {24'd0, hold_val});
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while a result is held on the outputs.
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; ALU_Sel = 4'b0000; in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_out",   {24'd0, ALU_Out},   32'd0);
    check("arst_carry", {31'd0, CarryOut},  32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    #13 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_out",   {24'd0, ALU_Out},   32'd0);

    lit("post_rst_add", 8'h7F, 8'h81, 4'b0000, 8'h00, 1'b1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
